// File: rtl/ls7212_delay_timer.sv
// LS7212-style programmable delay timer.
// Delays operate/release of one trigger by wb clocks; active-low output.
module ls7212_delay_timer #(
  parameter int WB_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WB_W-1:0] wb,
  input  logic            trigger,
  input  logic            mode_a,
  input  logic            mode_b,
  output logic            delay_out_n
);

  typedef enum logic [2:0] {
    IDLE,
    OP_DELAY,
    ACTIVE,
    REL_DELAY,
    PULSE
  } state_t;

  state_t          state_q, state_d;
  logic [WB_W-1:0] cnt_q, cnt_d;
  logic [WB_W-1:0] wb_q, wb_d;
  logic [1:0]      mode_q, mode;
  logic            trig_d, rise;
  logic            op_mode, rel_mode, shot;
  logic            wb_zero;
  logic            out_d;

  assign mode    = {mode_a, mode_b};
  assign rise    = trigger & ~trig_d;
  assign wb_zero = (wb == '0);

  always_comb begin
    op_mode  = 1'b0;
    rel_mode = 1'b0;
    shot     = 1'b0;
    unique case (1'b1)
      (mode == 2'b00): op_mode = 1'b1;
      (mode == 2'b01): rel_mode = 1'b1;
      (mode == 2'b10): begin
        op_mode  = 1'b1;
        rel_mode = 1'b1;
      end
      default: shot = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wb_d    = wb_q;
    if (mode != mode_q) begin
      // a mode switch abandons whatever interval was in progress
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (shot) begin
            if (rise && !wb_zero) begin
              state_d = PULSE;
              cnt_d   = {{(WB_W-1){1'b0}}, 1'b1};
              wb_d    = wb;
            end
          end else if (trigger) begin
            if (!op_mode || wb_zero) begin
              state_d = ACTIVE;
            end else begin
              state_d = OP_DELAY;
              cnt_d   = {{(WB_W-1){1'b0}}, 1'b1};
              wb_d    = wb;
            end
          end
        end
        OP_DELAY: begin
          if (!trigger) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == wb_q) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ACTIVE: begin
          if (!trigger) begin
            if (rel_mode && !wb_zero) begin
              state_d = REL_DELAY;
              cnt_d   = {{(WB_W-1){1'b0}}, 1'b1};
              wb_d    = wb;
            end else begin
              state_d = IDLE;
            end
          end
        end
        REL_DELAY: begin
          if (trigger) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else if (cnt_q == wb_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q == wb_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign out_d = !((state_d == ACTIVE) ||
                   (state_d == REL_DELAY) ||
                   (state_d == PULSE));

  always_ff @(posedge clk) begin
    // mode is captured even in reset so release does not look like a switch
    mode_q <= mode;
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wb_q        <= '0;
      trig_d      <= 1'b0;
      delay_out_n <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_q        <= wb_d;
      trig_d      <= trigger;
      delay_out_n <= out_d;
    end
  end

endmodule

// File: tb/tb_ls7212_delay_timer.sv
// Scoreboard bench for ls7212_delay_timer.
// Deadline-based reference model; monitor pops one expectation per edge.
module tb_ls7212_delay_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wb = 8'd0;
  logic       trigger = 1'b0;
  logic       mode_a = 1'b0;
  logic       mode_b = 1'b0;
  logic       delay_out_n;

  ls7212_delay_timer #(.WB_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb          (wb),
    .trigger     (trigger),
    .mode_a      (mode_a),
    .mode_b      (mode_b),
    .delay_out_n (delay_out_n)
  );

  always #5 clk = ~clk;

  bit   exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_cyc = 0;

  int   k = 0;
  int   op_at = -1;
  int   rel_at = -1;
  int   pulse_at = -1;
  bit   low = 1'b0;
  bit   prev_trig = 1'b0;
  logic [1:0] mode_prev = 2'b00;

  task automatic model(bit r, bit t, logic [1:0] m, int w);
    bit rise;
    k++;
    rise = t && !prev_trig;
    if (r || (m != mode_prev)) begin
      op_at = -1;
      rel_at = -1;
      pulse_at = -1;
      low = 1'b0;
      prev_trig = r ? 1'b0 : t;
      mode_prev = m;
      return;
    end
    if (m == 2'b11) begin
      if (pulse_at >= 0) begin
        if (k == pulse_at) begin
          pulse_at = -1;
          low = 1'b0;
        end
      end else if (rise && w != 0) begin
        pulse_at = k + w;
        low = 1'b1;
      end
    end else if (t) begin
      if (rel_at >= 0) begin
        rel_at = -1;
      end else if (low) begin
        low = 1'b1;
      end else if (op_at >= 0) begin
        if (k == op_at) begin
          op_at = -1;
          low = 1'b1;
        end
      end else if (m == 2'b01 || w == 0) begin
        low = 1'b1;
      end else begin
        op_at = k + w;
      end
    end else begin
      op_at = -1;
      if (rel_at >= 0) begin
        if (k == rel_at) begin
          rel_at = -1;
          low = 1'b0;
        end
      end else if (low) begin
        if (m == 2'b00 || w == 0) low = 1'b0;
        else rel_at = k + w;
      end
    end
    prev_trig = t;
    mode_prev = m;
  endtask

  task automatic step(bit r, bit t, logic [1:0] m, int w, int n);
    repeat (n) begin
      @(negedge clk);
      reset   = r;
      trigger = t;
      mode_a  = m[1];
      mode_b  = m[0];
      wb      = w[7:0];
      model(r, t, m, w);
      exp_q.push_back(!low);
    end
  endtask

  initial begin
    bit e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_cyc++;
        e = exp_q.pop_front();
        checks++;
        if (delay_out_n !== e) begin
          errors++;
          $display("FAIL out cyc=%0d got=%b exp=%b", mon_cyc, delay_out_n, e);
        end
      end
    end
  end

  initial begin
    bit         t;
    logic [1:0] m;
    int         w;
    step(1'b1, 1'b0, 2'b00, 0, 3);
    // mode 00, wb=10
    step(1'b0, 1'b1, 2'b00, 10, 15);
    step(1'b0, 1'b0, 2'b00, 10, 3);
    repeat (2) begin
      step(1'b0, 1'b1, 2'b00, 10, 2);
      step(1'b0, 1'b0, 2'b00, 10, 3);
    end
    // mode 01, wb=10
    step(1'b0, 1'b0, 2'b01, 10, 2);
    step(1'b0, 1'b1, 2'b01, 10, 5);
    step(1'b0, 1'b0, 2'b01, 10, 4);
    step(1'b0, 1'b1, 2'b01, 10, 4);
    step(1'b0, 1'b0, 2'b01, 10, 12);
    // mode 10, wb=3
    step(1'b0, 1'b0, 2'b10, 3, 2);
    step(1'b0, 1'b1, 2'b10, 3, 8);
    step(1'b0, 1'b0, 2'b10, 3, 5);
    step(1'b0, 1'b1, 2'b10, 3, 2);
    step(1'b0, 1'b0, 2'b10, 3, 5);
    // mode 11, wb=5
    step(1'b0, 1'b0, 2'b11, 5, 2);
    step(1'b0, 1'b1, 2'b11, 5, 20);
    step(1'b0, 1'b0, 2'b11, 5, 2);
    step(1'b0, 1'b1, 2'b11, 5, 1);
    step(1'b0, 1'b0, 2'b11, 5, 1);
    step(1'b0, 1'b1, 2'b11, 5, 1);
    step(1'b0, 1'b0, 2'b11, 5, 3);
    step(1'b0, 1'b1, 2'b11, 5, 2);
    step(1'b0, 1'b0, 2'b11, 5, 8);
    // wb=0 in every mode
    for (int i = 0; i < 4; i++) begin
      m = 2'(i);
      step(1'b0, 1'b0, m, 0, 2);
      repeat (12) step(1'b0, 1'($urandom_range(0, 1)), m, 0, 1);
    end
    // reset mid-operation, then mode change mid-delay
    step(1'b0, 1'b0, 2'b00, 10, 2);
    step(1'b0, 1'b1, 2'b00, 10, 13);
    step(1'b1, 1'b1, 2'b00, 10, 1);
    step(1'b0, 1'b1, 2'b00, 10, 13);
    step(1'b0, 1'b0, 2'b00, 10, 2);
    step(1'b0, 1'b1, 2'b00, 10, 4);
    step(1'b0, 1'b1, 2'b10, 10, 3);
    // maximum weight
    step(1'b0, 1'b0, 2'b00, 255, 2);
    step(1'b0, 1'b1, 2'b00, 255, 258);
    step(1'b0, 1'b0, 2'b00, 255, 2);
    // random soak
    t = 1'b0;
    m = 2'b00;
    w = 4;
    repeat (4000) begin
      if ($urandom_range(0, 5) == 0) t = ~t;
      if ($urandom_range(0, 99) == 0) m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) w = int'($urandom_range(0, 12));
      step(($urandom_range(0, 299) == 0), t, m, w, 1);
    end
    step(1'b0, 1'b0, 2'b00, 0, 2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
